// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the RV32M multiply/divide unit.
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    modport master (
        output start, funct3, op_a, op_b, rd_in, flush,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in, flush,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to make the four multiply ops single-cycle.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_unit_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic [4:0]          count;
    logic [2:0]          fn;
    logic                neg;
    logic [4:0]          rd_pend;
    logic [XLEN-1:0]     opnd;
    logic [2*XLEN-1:0]   acc;

    logic                sign_a, sign_b, in_neg;
    logic [XLEN-1:0]     in_mag_a, in_mag_b;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     special_res;
    logic [XLEN:0]       mul_sum, div_rem, div_diff;
    logic                div_ge;
    logic [2*XLEN-1:0]   acc_next;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0]   fast_prod;
`endif

    // Signed ops are computed on magnitudes; neg records whether the final value flips sign.
    function automatic logic [XLEN-1:0] sel_result(input logic [2:0] f, input logic n,
                                                   input logic [2*XLEN-1:0] v);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q, r;
        p = n ? -v : v;
        q = n ? -v[XLEN-1:0] : v[XLEN-1:0];
        r = n ? -v[2*XLEN-1:XLEN] : v[2*XLEN-1:XLEN];
        case (f)
            3'b000:                 sel_result = p[XLEN-1:0];
            3'b001, 3'b010, 3'b011: sel_result = p[2*XLEN-1:XLEN];
            3'b100, 3'b101:         sel_result = q;
            default:                sel_result = r;
        endcase
    endfunction

    always_comb begin
        sign_a      = bus.op_a[XLEN-1] & (bus.funct3 == 3'b001 || bus.funct3 == 3'b010 ||
                                          bus.funct3 == 3'b100 || bus.funct3 == 3'b110);
        sign_b      = bus.op_b[XLEN-1] & (bus.funct3 == 3'b001 || bus.funct3 == 3'b100 ||
                                          bus.funct3 == 3'b110);
        in_mag_a    = sign_a ? -bus.op_a : bus.op_a;
        in_mag_b    = sign_b ? -bus.op_b : bus.op_b;
        in_neg      = (bus.funct3 == 3'b110) ? sign_a : (sign_a ^ sign_b);
        div_zero    = bus.funct3[2] && (bus.op_b == '0);
        div_ovf     = bus.funct3[2] && !bus.funct3[0] &&
                      (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
        special_res = '0;
        if (div_zero)
            special_res = bus.funct3[1] ? bus.op_a : '1;
        else if (!bus.funct3[1])
            special_res = {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
        fast_prod   = (2*XLEN)'(in_mag_a) * (2*XLEN)'(in_mag_b);
`endif
    end

    // One iteration: multiply adds then shifts right; divide shifts left then trial-subtracts.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_rem  = acc[2*XLEN-1:XLEN-1];
        div_ge   = div_rem >= {1'b0, opnd};
        div_diff = div_rem - {1'b0, opnd};
        acc_next = fn[2] ? {(div_ge ? div_diff[XLEN-1:0] : div_rem[XLEN-1:0]),
                            acc[XLEN-2:0], div_ge}
                         : {mul_sum, acc[XLEN-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            fn         <= '0;
            neg        <= 1'b0;
            rd_pend    <= '0;
            opnd       <= '0;
            acc        <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.rd_out <= '0;
        end else if (bus.flush) begin
            state    <= IDLE;
            count    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        fn       <= bus.funct3;
                        neg      <= in_neg;
                        rd_pend  <= bus.rd_in;
                        count    <= '0;
                        bus.busy <= 1'b1;
                        opnd     <= bus.funct3[2] ? in_mag_b : in_mag_a;
                        acc      <= {{XLEN{1'b0}}, (bus.funct3[2] ? in_mag_a : in_mag_b)};
                        if (div_zero || div_ovf) begin
                            state      <= DONE;
                            bus.done   <= 1'b1;
                            bus.result <= special_res;
                            bus.rd_out <= bus.rd_in;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!bus.funct3[2]) begin
                            state      <= DONE;
                            bus.done   <= 1'b1;
                            bus.result <= sel_result(bus.funct3, in_neg, fast_prod);
                            bus.rd_out <= bus.rd_in;
`endif
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state      <= DONE;
                        bus.done   <= 1'b1;
                        bus.result <= sel_result(fn, neg, acc_next);
                        bus.rd_out <= rd_pend;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: spec vectors, abort/busy sequences and random ops vs. an arithmetic model.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if bus();

    muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    int          testsRun = 0;
    int          testsFailed = 0;
    logic [31:0] lastResult;
    logic [4:0]  lastRd;

    // Reference model straight from the RV32M definitions using 64-bit integer arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (f)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Edges after the accepting edge until done is visible.
    function automatic int expLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 0;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 0;
`endif
        return 32;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic addVec(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        vec_t v;
        v.name = name; v.f = f; v.a = a; v.b = b; v.rd = rd; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Issue one op and wait (bounded) for done; optionally pulse spurious starts while busy.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input bit noise,
                                 output int lat, output int busyCycles,
                                 output logic [31:0] res, output logic [4:0] rdo);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        busyCycles = 0;
        lat        = -1;
        res        = 'x;
        rdo        = 'x;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (bus.busy) busyCycles++;
            if (bus.done) begin
                lat = c;
                res = bus.result;
                rdo = bus.rd_out;
                break;
            end
            if (noise && c >= 2 && c <= 8) begin
                bus.start  = 1'b1;
                bus.funct3 = 3'b000;
                bus.op_a   = 32'd3;
                bus.op_b   = 32'd4;
                bus.rd_in  = ~rd;
            end else begin
                bus.start  = 1'b0;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic runAndCheck(input string name, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input logic [31:0] exp, input bit noise);
        int          lat, busyCycles, expLat;
        logic [31:0] res;
        logic [4:0]  rdo;
        expLat = expLatency(f, a, b);
        applyStimulus(f, a, b, rd, noise, lat, busyCycles, res, rdo);
        checkOutput({name, " result"}, res, exp);
        checkOutput({name, " rd_out"}, 32'(rdo), 32'(rd));
        checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({name, " busy cycles"}, 32'(busyCycles), 32'(expLat + 1));
        // A start offered in the DONE cycle must not be taken.
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.op_a   = 32'd5;
        bus.op_b   = 32'd6;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        checkOutput({name, " done pulse width"}, 32'(bus.done), 32'd0);
        checkOutput({name, " idle after done"}, 32'(bus.busy), 32'd0);
        checkOutput({name, " result hold"}, bus.result, exp);
        lastResult = exp;
        lastRd     = rd;
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  rd;
        bit          sawDone;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.rd_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset result", bus.result, 32'd0);
        checkOutput("reset rd_out", 32'(bus.rd_out), 32'd0);
        rst = 1'b0;

        addVec("MUL 7*-3",         3'b000, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB);
        addVec("MULH min*min",     3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000);
        addVec("MULHU max*max",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE);
        addVec("MULHSU -1*max",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF);
        addVec("DIV -7/2",         3'b100, 32'hFFFF_FFF9, 32'd2,          5'd7,  32'hFFFF_FFFD);
        addVec("REM -7/2",         3'b110, 32'hFFFF_FFF9, 32'd2,          5'd8,  32'hFFFF_FFFF);
        addVec("DIVU 100/7",       3'b101, 32'd100,        32'd7,          5'd9,  32'd14);
        addVec("REMU 100/7",       3'b111, 32'd100,        32'd7,          5'd10, 32'd2);
        addVec("DIVU 5/0",         3'b101, 32'd5,          32'd0,          5'd11, 32'hFFFF_FFFF);
        addVec("REM 5/0",          3'b110, 32'd5,          32'd0,          5'd12, 32'd5);
        addVec("DIV ovf",          3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
        addVec("REM ovf",          3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'd0);

        foreach (vecs[i])
            runAndCheck(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 1'b0);

        // Spurious starts while busy must not disturb the op in flight.
        runAndCheck("DIVU noisy", 3'b101, 32'd100, 32'd7, 5'd17, 32'd14, 1'b1);

        // Flush ten cycles into a divide: no done, outputs keep the previous op's values.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = 3'b100;
        bus.op_a   = 32'd1000;
        bus.op_b   = 32'd3;
        bus.rd_in  = 5'd21;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        checkOutput("flush busy", 32'(bus.busy), 32'd0);
        checkOutput("flush done", 32'(bus.done), 32'd0);
        checkOutput("flush result kept", bus.result, lastResult);
        checkOutput("flush rd_out kept", 32'(bus.rd_out), 32'(lastRd));
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) sawDone = 1'b1;
        end
        checkOutput("flush suppresses done", 32'(sawDone), 32'd0);

        // Flush wins over a simultaneous start.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        bus.funct3 = 3'b000;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        checkOutput("flush beats start", 32'(bus.busy), 32'd0);

        runAndCheck("MUL 3*4 after flush", 3'b000, 32'd3, 32'd4, 5'd22, 32'd12, 1'b0);

        // Reset in the middle of a multiply returns every output to zero.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.op_a   = 32'h1234;
        bus.op_b   = 32'h5678;
        bus.rd_in  = 5'd30;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("mid-op reset busy", 32'(bus.busy), 32'd0);
        checkOutput("mid-op reset done", 32'(bus.done), 32'd0);
        checkOutput("mid-op reset result", bus.result, 32'd0);
        checkOutput("mid-op reset rd_out", 32'(bus.rd_out), 32'd0);

        for (int i = 0; i < 60; i++) begin
            f  = 3'($urandom_range(0, 7));
            rd = 5'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                3: b = 32'($urandom_range(0, 15)) - 32'd8;
                default: ;
            endcase
            runAndCheck($sformatf("rand%0d f=%0d a=%08h b=%08h", i, f, a, b), f, a, b, rd,
                        refModel(f, a, b), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
